reaction_timer: RTL and testbench

Measures a human reaction time in milliseconds on the DE10-Lite board. It sits between the debounced KEY inputs and the BCD-to-seven-segment display path, and is driven by the 50 MHz board clock. After a start press it waits a pseudo-random delay, then lights a cue LED and counts whole milliseconds until the stop press. The result is presented as four BCD digits, with false-start and overflow flags.

---
 rtl/reaction_timer_if.sv | 21 ++
 rtl/reaction_timer.sv | 149 ++++++++++++++
 tb/tb_reaction_timer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_if.sv
// rtl/reaction_timer_if.sv - button inputs and result outputs of the reaction timer
interface reaction_timer_if;
   logic        start;
   logic        stop;
   logic        cue;
   logic        busy;
   logic        done;
   logic        early;
   logic        overflow;
   logic [15:0] ms_bcd;

   modport master (
      output start, stop,
      input  cue, busy, done, early, overflow, ms_bcd
   );

   modport slave (
      input  start, stop,
      output cue, busy, done, early, overflow, ms_bcd
   );
endinterface

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - reaction timer: random cue delay, millisecond BCD count, foul/overflow flags
module reaction_timer #(
   parameter int TICK_DIV     = 50000,
   parameter int DELAY_MS_MIN = 1000
) (
   input logic            clk,
   input logic            rst_n,
   reaction_timer_if.slave tif
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DLY_W = $clog2(DELAY_MS_MIN + 1021);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DELAY = 3'd1,
      S_COUNT = 3'd2,
      S_DONE  = 3'd3,
      S_FOUL  = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic               start_q, stop_q;
   logic [7:0]         lfsr_q, lfsr_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DLY_W-1:0]   delay_q, delay_d;
   logic [15:0]        ms_bcd_q, ms_bcd_d;
   logic               overflow_q, overflow_d;
   logic               cue_q, cue_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               early_q, early_d;

   logic               start_edge, stop_edge, tick;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      start_edge = tif.start & ~start_q;
      stop_edge  = tif.stop & ~stop_q;
      tick       = (div_q == DIV_W'(TICK_DIV - 1));

      // x^8+x^6+x^5+x^4+1, shifted left with feedback into bit 0
      lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      div_d      = tick ? '0 : div_q + DIV_W'(1);
      state_d    = state_q;
      delay_d    = delay_q;
      ms_bcd_d   = ms_bcd_q;
      overflow_d = overflow_q;

      case (state_q)
         S_DELAY: begin
            if (stop_edge) begin
               state_d = S_FOUL;
            end else if (tick) begin
               delay_d = delay_q - DLY_W'(1);
               if (delay_q == DLY_W'(1)) begin
                  state_d = S_COUNT;
               end
            end
         end
         S_COUNT: begin
            // a stop sampled together with a tick wins; that tick is not counted
            if (stop_edge) begin
               state_d = S_DONE;
            end else if (tick) begin
               if (ms_bcd_q == 16'h9999) begin
                  overflow_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  ms_bcd_d = bcd_inc(ms_bcd_q);
               end
            end
         end
         default: begin
            if (start_edge) begin
               state_d    = S_DELAY;
               delay_d    = DLY_W'(DELAY_MS_MIN) + DLY_W'({lfsr_q, 2'b00});
               ms_bcd_d   = 16'h0000;
               overflow_d = 1'b0;
            end
         end
      endcase

      // the millisecond phase restarts whenever a timed state is entered
      if ((state_d != state_q) && ((state_d == S_DELAY) || (state_d == S_COUNT))) begin
         div_d = '0;
      end

      cue_d   = (state_d == S_COUNT);
      busy_d  = (state_d == S_DELAY) || (state_d == S_COUNT);
      done_d  = (state_d == S_DONE);
      early_d = (state_d == S_FOUL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         lfsr_q     <= 8'h01;
         div_q      <= '0;
         delay_q    <= '0;
         ms_bcd_q   <= 16'h0000;
         overflow_q <= 1'b0;
         cue_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         early_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= tif.start;
         stop_q     <= tif.stop;
         lfsr_q     <= lfsr_d;
         div_q      <= div_d;
         delay_q    <= delay_d;
         ms_bcd_q   <= ms_bcd_d;
         overflow_q <= overflow_d;
         cue_q      <= cue_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         early_q    <= early_d;
      end
   end

   assign tif.cue      = cue_q;
   assign tif.busy     = busy_q;
   assign tif.done     = done_q;
   assign tif.early    = early_q;
   assign tif.overflow = overflow_q;
   assign tif.ms_bcd   = ms_bcd_q;

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - scoreboard bench for reaction_timer with TICK_DIV=4, DELAY_MS_MIN=2
module tb_reaction_timer;

   localparam int T   = 4;
   localparam int MIN = 2;

   typedef enum int {EV_CUE = 0, EV_DONE = 1, EV_FOUL = 2} ev_kind_e;
   typedef struct {
      ev_kind_e    kind;
      int          cyc;
      logic [15:0] bcd;
      logic        ovf;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] m_lfsr;
   ev_t  exp_q[$];
   logic cue_p = 1'b0, done_p = 1'b0, early_p = 1'b0;

   reaction_timer_if tif ();

   reaction_timer #(.TICK_DIV(T), .DELAY_MS_MIN(MIN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tif   (tif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 8'h01;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic on_event(input ev_kind_e k);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event actual=%0d required=none (cycle %0d)", int'(k), cyc);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", int'(k), int'(e.kind));
         chk("event_cycle", cyc, e.cyc);
         if (k != EV_CUE) begin
            chk("result_bcd", tif.ms_bcd, e.bcd);
            chk("result_overflow", tif.overflow, e.ovf);
            chk("result_busy", tif.busy, 0);
            chk("result_cue", tif.cue, 0);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         cue_p   <= 1'b0;
         done_p  <= 1'b0;
         early_p <= 1'b0;
      end else begin
         if (tif.cue && !cue_p)     on_event(EV_CUE);
         if (tif.done && !done_p)   on_event(EV_DONE);
         if (tif.early && !early_p) on_event(EV_FOUL);
         cue_p   <= tif.cue;
         done_p  <= tif.done;
         early_p <= tif.early;
      end
   end

   task automatic push(input ev_kind_e k, input int c, input logic [15:0] b, input logic o);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.bcd  = b;
      e.ovf  = o;
      exp_q.push_back(e);
   endtask

   task automatic at_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_start(output int k, output int d);
      @(negedge clk) tif.start = 1'b0;
      @(negedge clk) tif.start = 1'b1;
      k = cyc + 1;
      d = MIN + 4 * int'(m_lfsr);
   endtask

   task automatic pulse_stop_at(input int c);
      at_cyc(c);
      tif.stop = 1'b1;
      @(negedge clk) tif.stop = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cue"}, tif.cue, 0);
      chk({tag, "_busy"}, tif.busy, 0);
      chk({tag, "_done"}, tif.done, 0);
      chk({tag, "_early"}, tif.early, 0);
      chk({tag, "_overflow"}, tif.overflow, 0);
      chk({tag, "_ms_bcd"}, tif.ms_bcd, 16'h0000);
   endtask

   initial begin
      int k, d, e;
      tif.start = 1'b0;
      tif.stop  = 1'b0;

      repeat (3) @(negedge clk);
      chk_all_zero("reset");

      // stop in IDLE does nothing
      rst_n = 1'b1;
      @(negedge clk) tif.stop = 1'b1;
      @(negedge clk) tif.stop = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_stop_busy", tif.busy, 0);
      chk("idle_stop_early", tif.early, 0);
      chk("idle_stop_done", tif.done, 0);

      // first edge after reset uses lfsr=01: delay 2+4=6 ms = 24 cycles
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tif.start = 1'b1;
      k = cyc + 1;
      push(EV_CUE, k + 24, 16'h0000, 1'b0);
      at_cyc(k + 34);
      tif.start = 1'b0;
      chk("mid_count_bcd", tif.ms_bcd, 16'h0002);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");

      // LFSR restarted: again 24 cycles; nominal 150 COUNT cycles -> 0037
      @(negedge clk);
      rst_n = 1'b1;
      tif.start = 1'b1;
      k = cyc + 1;
      e = k + 24;
      push(EV_CUE, e, 16'h0000, 1'b0);
      push(EV_DONE, e + 151, 16'h0037, 1'b0);
      pulse_stop_at(e + 150);
      at_cyc(e + 171);
      chk("held_start_done", tif.done, 1);
      chk("held_start_busy", tif.busy, 0);
      chk("held_start_early", tif.early, 0);

      // false start in DELAY cycle 5
      do_start(k, d);
      push(EV_FOUL, k + 6, 16'h0000, 1'b0);
      pulse_stop_at(k + 5);
      at_cyc(k + 8);
      chk("foul_early", tif.early, 1);
      chk("foul_busy", tif.busy, 0);

      // restart clears early; stop on the final DELAY tick is a foul
      do_start(k, d);
      @(negedge clk);
      chk("restart_early", tif.early, 0);
      chk("restart_busy", tif.busy, 1);
      push(EV_FOUL, k + 4 * d, 16'h0000, 1'b0);
      pulse_stop_at(k + 4 * d - 1);
      at_cyc(k + 4 * d + 3);

      // start edges in DELAY and COUNT ignored; stop with tick at 0009 -> 0009
      do_start(k, d);
      e = k + 4 * d;
      push(EV_CUE, e, 16'h0000, 1'b0);
      at_cyc(k + 3);
      tif.start = 1'b0;
      at_cyc(k + 5);
      tif.start = 1'b1;
      at_cyc(e + 5);
      tif.start = 1'b0;
      at_cyc(e + 7);
      tif.start = 1'b1;
      push(EV_DONE, e + 40, 16'h0009, 1'b0);
      pulse_stop_at(e + 39);
      at_cyc(e + 45);

      // overflow: 10000th tick saturates
      do_start(k, d);
      e = k + 4 * d;
      push(EV_CUE, e, 16'h0000, 1'b0);
      push(EV_DONE, e + 40000, 16'h9999, 1'b1);
      at_cyc(e + 40004);
      chk("overflow_done", tif.done, 1);

      chk("pending_events", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
